// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: pipeline/out-of-order result inputs, scoreboard
// query/issue, and the register-file write port.
interface wb_arbiter_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_waddr;
  logic [31:0]   pipe_wdata;
  logic          async_valid;
  logic          async_ready;
  logic [4:0]    async_waddr;
  logic [31:0]   async_wdata;
  logic          issue_set;
  logic [4:0]    issue_addr;
  logic [4:0]    qaddr1;
  logic [4:0]    qaddr2;
  logic          busy1;
  logic          busy2;
  logic          we;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic          stall_req;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  async_valid, async_waddr, async_wdata,
    input  issue_set, issue_addr, qaddr1, qaddr2,
    output async_ready, busy1, busy2,
    output we, waddr, wdata, stall_req, fifo_count
  );

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output async_valid, async_waddr, async_wdata,
    output issue_set, issue_addr, qaddr1, qaddr2,
    input  async_ready, busy1, busy2,
    input  we, waddr, wdata, stall_req, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline results have priority over a small in-order FIFO of
// out-of-order results; tracks pending registers and requests stalls on starvation.
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_next;
  logic [SW-1:0] starve, starve_next;
  logic [31:0]   pending, pending_next;
  logic          we_q, stall_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wdata_q;

  logic          empty, full, pipe_sel, pop, push;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pipe_sel  = bus.pipe_we && (bus.pipe_waddr != '0);
  assign pop       = !pipe_sel && !empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign bus.async_ready = !full || pop;
  assign push      = bus.async_valid && bus.async_ready;
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    starve_next = '0;
    if (!empty && !pop)
      starve_next = (starve == SW'(STARVE_LIMIT)) ? starve : starve + SW'(1);
  end

  // Clear for the emitted address is applied first so a same-cycle issue wins.
  always_comb begin
    pending_next = pending;
    if (pop && head_addr != '0)
      pending_next[head_addr] = 1'b0;
    if (bus.issue_set && bus.issue_addr != '0)
      pending_next[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.async_waddr;
      fifo_data[wr_ptr] <= bus.async_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      starve  <= '0;
      pending <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      stall_q <= 1'b0;
    end else begin
      count   <= count_next;
      starve  <= starve_next;
      pending <= pending_next;
      stall_q <= (starve_next == SW'(STARVE_LIMIT)) || (count_next == (AW+1)'(DEPTH));
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (pipe_sel) begin
        we_q    <= 1'b1;
        waddr_q <= bus.pipe_waddr;
        wdata_q <= bus.pipe_wdata;
      end else if (pop && head_addr != '0) begin
        we_q    <= 1'b1;
        waddr_q <= head_addr;
        wdata_q <= head_data;
      end else begin
        we_q    <= 1'b0;
      end
    end
  end

  assign bus.busy1      = (bus.qaddr1 != '0) && pending[bus.qaddr1];
  assign bus.busy2      = (bus.qaddr2 != '0) && pending[bus.qaddr2];
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.stall_req  = stall_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_wb_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  bit   [31:0] pend;
  int          starve;
  bit          m_we, m_stall, m_data_known;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = '0; starve = 0; m_we = 0; m_stall = 0;
    m_waddr = '0; m_wdata = '0; m_data_known = 1;
  endtask

  task automatic idle();
    bus.pipe_we = 0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
    bus.async_valid = 0; bus.async_waddr = '0; bus.async_wdata = '0;
    bus.issue_set = 0; bus.issue_addr = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit pipe_ok, popping, accept, was_empty;
    ent_t h;
    #1;
    pipe_ok   = bus.pipe_we && bus.pipe_waddr != 0;
    was_empty = (q.size() == 0);
    popping   = !pipe_ok && !was_empty;
    accept    = bus.async_valid && (q.size() < DEPTH || popping);
    check("async_ready", bus.async_ready, (q.size() < DEPTH || popping));
    check("fifo_count", bus.fifo_count, q.size());
    check("busy1", bus.busy1, pend[bus.qaddr1] && bus.qaddr1 != 0);
    check("busy2", bus.busy2, pend[bus.qaddr2] && bus.qaddr2 != 0);
    m_data_known = 1;
    if (pipe_ok) begin
      m_we = 1; m_waddr = bus.pipe_waddr; m_wdata = bus.pipe_wdata;
    end else if (popping) begin
      h = q.pop_front();
      if (h.a != 0) begin
        m_we = 1; m_waddr = h.a; m_wdata = h.d; pend[h.a] = 0;
      end else begin
        m_we = 0; m_data_known = 0;
      end
    end else begin
      m_we = 0;
    end
    if (bus.issue_set && bus.issue_addr != 0) pend[bus.issue_addr] = 1;
    if (accept) q.push_back('{bus.async_waddr, bus.async_wdata});
    if (popping || was_empty) starve = 0;
    else if (starve < LIMIT) starve++;
    m_stall = (starve == LIMIT) || (q.size() == DEPTH);
    @(posedge clk);
    #1;
    check("we", bus.we, m_we);
    check("stall_req", bus.stall_req, m_stall);
    if (m_data_known) begin
      check("waddr", bus.waddr, m_waddr);
      check("wdata", bus.wdata, m_wdata);
    end
  endtask

  task automatic check_reset_state();
    check("rst_we", bus.we, 0);
    check("rst_waddr", bus.waddr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_stall", bus.stall_req, 0);
    check("rst_ready", bus.async_ready, 1);
    check("rst_count", bus.fifo_count, 0);
    check("rst_busy1", bus.busy1, 0);
    check("rst_busy2", bus.busy2, 0);
  endtask

  initial begin
    idle();
    bus.qaddr1 = 5; bus.qaddr2 = 5;
    model_reset();
    repeat (2) @(posedge clk);
    #1; check_reset_state();
    #2 rst = 0;
    step();

    // Pipeline only, then pipeline write to r0 is a non-write.
    bus.pipe_we = 1; bus.pipe_waddr = 3; bus.pipe_wdata = 32'h12345678; step();
    bus.pipe_waddr = 0; step();
    idle(); step();

    // Async path with scoreboard.
    bus.qaddr1 = 7;
    bus.issue_set = 1; bus.issue_addr = 7; step();
    idle(); bus.async_valid = 1; bus.async_waddr = 7; bus.async_wdata = 32'hDEADBEEF; step();
    idle(); step();
    step();

    // Priority and starvation.
    bus.pipe_we = 1; bus.pipe_waddr = 4; bus.async_valid = 1; bus.async_waddr = 12;
    bus.async_wdata = 32'hA5A5_0001; step();
    bus.async_valid = 0;
    for (int i = 0; i < 5; i++) begin
      bus.pipe_wdata = 32'h100 + i; step();
    end
    idle(); step(); step();

    // Full, refused fifth offer, drain, then refill across pointer wrap.
    bus.pipe_we = 1; bus.pipe_waddr = 4;
    for (int i = 0; i < 5; i++) begin
      bus.async_valid = 1; bus.async_waddr = 5'(16 + i); bus.async_wdata = 32'hF000 + i; step();
    end
    idle(); repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      bus.async_valid = 1; bus.async_waddr = 5'(20 + i); bus.async_wdata = 32'hE000 + i; step();
    end
    idle(); repeat (5) step();

    // Same-cycle emit and re-issue of r9; discarded r0 entry.
    bus.qaddr2 = 9;
    bus.issue_set = 1; bus.issue_addr = 9; step();
    idle(); bus.async_valid = 1; bus.async_waddr = 9; bus.async_wdata = 32'h9999; step();
    idle(); bus.issue_set = 1; bus.issue_addr = 9; step();
    idle(); step();
    bus.async_valid = 1; bus.async_waddr = 0; bus.async_wdata = 32'h0BAD; step();
    idle(); step(); step();

    // Push while full and popping.
    bus.pipe_we = 1; bus.pipe_waddr = 2;
    for (int i = 0; i < 4; i++) begin
      bus.async_valid = 1; bus.async_waddr = 5'(24 + i); bus.async_wdata = 32'hC000 + i; step();
    end
    bus.pipe_we = 0; bus.async_waddr = 28; bus.async_wdata = 32'hC004; step();
    idle(); repeat (6) step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bus.pipe_we     = ($urandom_range(0, 99) < 55);
      bus.pipe_waddr  = 5'($urandom_range(0, 31));
      bus.pipe_wdata  = $urandom;
      bus.async_valid = ($urandom_range(0, 99) < 40);
      bus.async_waddr = 5'($urandom_range(0, 31));
      bus.async_wdata = $urandom;
      bus.issue_set   = ($urandom_range(0, 99) < 30);
      bus.issue_addr  = 5'($urandom_range(0, 31));
      bus.qaddr1      = 5'($urandom_range(0, 31));
      bus.qaddr2      = 5'($urandom_range(0, 31));
      step();
    end

    // Asynchronous reset mid-cycle with state in flight.
    bus.pipe_we = 1; bus.pipe_waddr = 6; bus.pipe_wdata = 32'h77;
    bus.async_valid = 1; bus.async_waddr = 8; bus.async_wdata = 32'h88; step();
    idle(); bus.qaddr1 = 5; bus.qaddr2 = 5;
    #2 rst = 1;
    #1 check_reset_state();
    model_reset();
    #2 rst = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule
